memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Round-robin arbiter sharing the single-outstanding cache-side port of the clock-crossing memory interface between `N_PORTS` requesters (instruction cache, data cache, write-back buffer). It latches one request at a time, drives the interface's `SIG_RD`/`SIG_WR`/`IN_ADDR`/`IN_DATA` level handshake, and returns a one-cycle per-port acknowledge with read data. A watchdog releases a requester whose transfer never completes and flags the fault. The block is purely in the cache clock domain.

## Interface
- `N_PORTS`, 2, number of requesters (2..4).
- `c_ADDR_SIZE`, 16, byte address width (from `Constants.vh`).
- `c_RAM_DATA_SIZE`, 128, line width in bits (from `Constants.vh`).
- `TIMEOUT`, 1023, max cycles in `WAIT` before the watchdog fires (≥ 8).
- `CACHE_CLK` in 1: the only clock, rising edge.
- `CACHE_RESET` in 1: synchronous, active-low reset.
- `P_RD` in `N_PORTS`: per-port read request, level, held until that port's `P_ACK`.
- `P_WR` in `N_PORTS`: per-port write request, level, same rule.
- `P_ADDR` in `N_PORTS*c_ADDR_SIZE`: packed addresses, port i at `[i*c_ADDR_SIZE +: c_ADDR_SIZE]`.
- `P_WDATA` in `N_PORTS*c_RAM_DATA_SIZE`: packed write lines.
- `P_ACK` out `N_PORTS`: one-cycle completion pulse to the granted port.
- `P_TOUT` out 1: pulses with `P_ACK` when the completion is a watchdog release.
- `P_RDATA` out `c_RAM_DATA_SIZE`: shared read-data bus, valid in the `P_ACK` cycle.
- `GRANT_ID` out 2: index of the port currently or last served.
- `BUSY` out 1: high from issue until return to `IDLE`.
- `ERR` out 1: sticky; set on watchdog expiry or on simultaneous `P_RD`/`P_WR` from one port.
- `SIG_RD`, `SIG_WR` out 1 each: to the memory interface.
- `MEM_ADDR` out `c_ADDR_SIZE`; `MEM_WDATA` out `c_RAM_DATA_SIZE`: to the interface's `IN_ADDR`/`IN_DATA`.
- `MEM_ACK` in 1; `MEM_RDATA` in `c_RAM_DATA_SIZE`: from the interface's `ACK`/`OUT_DATA`.

## Operation
- States: `IDLE`, `WAIT`, `DRAIN`, `GAP`.
- `IDLE`: a port requests if `P_RD[i] | P_WR[i]`. The winner is the first requesting port at or after `rr_ptr`, scanning upward modulo `N_PORTS`. On a winner:
  - register `MEM_ADDR`, `MEM_WDATA` and `GRANT_ID`;
  - assert `SIG_RD` if `P_RD`, otherwise `SIG_WR`;
  - clear `wd_cnt`, go to `WAIT`.
- Both `P_RD[i]` and `P_WR[i]` high on the winner: treat as write and set `ERR`.
- `WAIT`: `SIG_*`, `MEM_ADDR` and `MEM_WDATA` stay stable. `wd_cnt` increments each cycle.
  - `MEM_ACK`=1: drop `SIG_*`. On a read, register `P_RDATA <= MEM_RDATA`. Pulse `P_ACK[g]`, go to `GAP`.
  - Else `wd_cnt == TIMEOUT-1`: drop `SIG_*`, pulse `P_ACK[g]` and `P_TOUT`, set `ERR`, go to `DRAIN`.
- `DRAIN`: wait for the late `MEM_ACK`, discard its data, go to `GAP`. The interface cannot abort a transfer, so no new issue is allowed before its `ACK`. There is no second timeout.
- `GAP`: exactly one cycle. `P_ACK`/`P_TOUT` return to 0, `rr_ptr <= (g+1) mod N_PORTS`, go to `IDLE`. This guarantees `SIG_*` is low for ≥2 edges, which prevents re-trigger off the interface's one-cycle `ACK`.
- `MEM_ACK` seen in `IDLE` or `GAP`: ignored; `ERR` is not set.
- Requester rule: deassert the request no later than the edge after its `P_ACK`. `IDLE` is re-entered one edge later, so the old request is never re-sampled.
- Widths:
  - `wd_cnt` is `$clog2(TIMEOUT+1)` bits and saturates, never wraps.
  - `rr_ptr` is `$clog2(N_PORTS)` bits, with explicit wrap at `N_PORTS-1`.

## Timing
- Reset (`CACHE_RESET`=0 at an edge) forces:
  - state `IDLE`, `rr_ptr`=0, `wd_cnt`=0;
  - `SIG_RD`=`SIG_WR`=0, `P_ACK`=0, `P_TOUT`=0, `BUSY`=0, `ERR`=0, `GRANT_ID`=0, `P_RDATA`=0, `MEM_ADDR`=0, `MEM_WDATA`=0.
- Reset mid-transfer abandons it silently. The memory interface must be reset in the same cycle (system rule).
- Request high before edge k (in `IDLE`) → `SIG_*` high after edge k.
- `MEM_ACK` high before edge m → `P_ACK` high for cycle m..m+1, `SIG_*` low after m.
- Next grant is possible at edge m+2, giving ≥2 cycles of arbiter overhead per transfer.
- `BUSY` = state ≠ `IDLE`.

## Structure
- `Constants.vh` gains `c_ARB_PORTS_MAX`=4, `c_ARB_TIMEOUT_DEFAULT`=1023 and the state encodings `c_ARB_IDLE`..`c_ARB_GAP`. `c_ADDR_SIZE`/`c_RAM_DATA_SIZE` are reused.
- One sub-module, `rr_picker`: combinational. Inputs are the request vector and `rr_ptr`; outputs are `valid` and the `index`. It is unit-testable standalone.

## Test plan
- Port 0 reads 0x0040 → `SIG_RD` 1 cycle after request; bench returns `MEM_ACK` after 20 cycles with 0x0123…EF → `P_ACK[0]` single pulse, `P_RDATA` equals the line, `SIG_RD` low for ≥2 edges.
- Ports 0 and 1 request continuously → grants alternate 0,1,0,1 over 4 transfers; `GRANT_ID` matches each `P_ACK`.
- Port 1 writes 0x00A0 with line 0xFFFF…0000 → `SIG_WR`, `MEM_ADDR`=0x00A0 and `MEM_WDATA` stay stable until `MEM_ACK`; no `SIG_RD` ever.
- `TIMEOUT`=8, no `MEM_ACK` → after 8 `WAIT` cycles `P_ACK`+`P_TOUT` pulse and `ERR`=1. A new request is not issued until the bench's late `MEM_ACK`, then is served normally.
- Port 0 asserts `P_RD`=`P_WR`=1 → issued as write, `ERR`=1. Stray `MEM_ACK` in `IDLE` → no `P_ACK`, state unchanged.
- Reset asserted in `WAIT` → next edge all outputs at reset values. After release, port 0 is granted first.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the cache-side memory arbiter: default sizes, FSM
// encodings and the round-robin pointer wrap helper.
package memory_arbiter_pkg;

    localparam int c_ARB_ADDR_SIZE       = 16;
    localparam int c_ARB_DATA_SIZE       = 128;
    localparam int c_ARB_PORTS_MAX       = 4;
    localparam int c_ARB_TIMEOUT_DEFAULT = 1023;

    localparam logic [1:0] c_ARB_IDLE  = 2'd0;
    localparam logic [1:0] c_ARB_WAIT  = 2'd1;
    localparam logic [1:0] c_ARB_DRAIN = 2'd2;
    localparam logic [1:0] c_ARB_GAP   = 2'd3;

    // Port after cur, wrapping explicitly at n-1 so non-power-of-two counts work.
    function automatic int unsigned next_port(input int unsigned cur, input int unsigned n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting port at or after ptr,
// scanning upward modulo N_PORTS.
module memory_arbiter_rr_picker #(
    parameter int N_PORTS = 2,
    parameter int PTR_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   index
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // Scan from the farthest candidate down so the nearest one is written last.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            cand = int'(ptr) + j;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            cand_idx = PTR_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the single-outstanding memory interface port.
// Handshake: a port holds P_RD/P_WR (level) until its one-cycle P_ACK; toward memory SIG_* stays high until MEM_ACK.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int c_ADDR_SIZE     = c_ARB_ADDR_SIZE,
    parameter int c_RAM_DATA_SIZE = c_ARB_DATA_SIZE,
    parameter int TIMEOUT         = c_ARB_TIMEOUT_DEFAULT
) (
    input  logic                                 CACHE_CLK,
    input  logic                                 CACHE_RESET,
    input  logic [N_PORTS-1:0]                   P_RD,
    input  logic [N_PORTS-1:0]                   P_WR,
    input  logic [N_PORTS*c_ADDR_SIZE-1:0]       P_ADDR,
    input  logic [N_PORTS*c_RAM_DATA_SIZE-1:0]   P_WDATA,
    output logic [N_PORTS-1:0]                   P_ACK,
    output logic                                 P_TOUT,
    output logic [c_RAM_DATA_SIZE-1:0]           P_RDATA,
    output logic [$clog2(c_ARB_PORTS_MAX)-1:0]   GRANT_ID,
    output logic                                 BUSY,
    output logic                                 ERR,
    output logic                                 SIG_RD,
    output logic                                 SIG_WR,
    output logic [c_ADDR_SIZE-1:0]               MEM_ADDR,
    output logic [c_RAM_DATA_SIZE-1:0]           MEM_WDATA,
    input  logic                                 MEM_ACK,
    input  logic [c_RAM_DATA_SIZE-1:0]           MEM_RDATA,
    output logic [1:0]                           dbg_state
);

    localparam int PTR_W = $clog2(N_PORTS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    logic [1:0]                 state_q,     state_d;
    logic [PTR_W-1:0]           rr_ptr_q,    rr_ptr_d;
    logic [WD_W-1:0]            wd_cnt_q,    wd_cnt_d;
    logic [PTR_W-1:0]           grant_q,     grant_d;
    logic                       sig_rd_q,    sig_rd_d;
    logic                       sig_wr_q,    sig_wr_d;
    logic [c_ADDR_SIZE-1:0]     mem_addr_q,  mem_addr_d;
    logic [c_RAM_DATA_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [N_PORTS-1:0]         p_ack_q,     p_ack_d;
    logic                       p_tout_q,    p_tout_d;
    logic                       err_q,       err_d;
    logic [c_RAM_DATA_SIZE-1:0] p_rdata_q,   p_rdata_d;

    logic                       pick_valid;
    logic [PTR_W-1:0]           pick_idx;
    logic [c_ADDR_SIZE-1:0]     win_addr;
    logic [c_RAM_DATA_SIZE-1:0] win_wdata;

    memory_arbiter_rr_picker #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req   (P_RD | P_WR),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (PTR_W'(i) == pick_idx) begin
                win_addr  = P_ADDR[i*c_ADDR_SIZE +: c_ADDR_SIZE];
                win_wdata = P_WDATA[i*c_RAM_DATA_SIZE +: c_RAM_DATA_SIZE];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wd_cnt_d    = wd_cnt_q;
        grant_d     = grant_q;
        sig_rd_d    = sig_rd_q;
        sig_wr_d    = sig_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p_ack_d     = '0;
        p_tout_d    = 1'b0;
        err_d       = err_q;
        p_rdata_d   = p_rdata_q;
        case (state_q)
            c_ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    // A port raising both strobes is served as a write and flagged.
                    sig_wr_d    = P_WR[pick_idx];
                    sig_rd_d    = ~P_WR[pick_idx];
                    if (P_RD[pick_idx] && P_WR[pick_idx]) begin
                        err_d = 1'b1;
                    end
                    wd_cnt_d = '0;
                    state_d  = c_ARB_WAIT;
                end
            end
            c_ARB_WAIT: begin
                if (wd_cnt_q != WD_MAX) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                if (MEM_ACK) begin
                    if (sig_rd_q) begin
                        p_rdata_d = MEM_RDATA;
                    end
                    sig_rd_d          = 1'b0;
                    sig_wr_d          = 1'b0;
                    p_ack_d[grant_q]  = 1'b1;
                    state_d           = c_ARB_GAP;
                end else if (wd_cnt_q == WD_LAST) begin
                    sig_rd_d          = 1'b0;
                    sig_wr_d          = 1'b0;
                    p_ack_d[grant_q]  = 1'b1;
                    p_tout_d          = 1'b1;
                    err_d             = 1'b1;
                    state_d           = c_ARB_DRAIN;
                end
            end
            c_ARB_DRAIN: begin
                // The interface cannot abort, so hold off new issues until its late ACK.
                if (MEM_ACK) begin
                    state_d = c_ARB_GAP;
                end
            end
            c_ARB_GAP: begin
                rr_ptr_d = PTR_W'(next_port(int'(grant_q), N_PORTS));
                state_d  = c_ARB_IDLE;
            end
            default: begin
                state_d = c_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CACHE_CLK) begin
        if (!CACHE_RESET) begin
            state_q     <= c_ARB_IDLE;
            rr_ptr_q    <= '0;
            wd_cnt_q    <= '0;
            grant_q     <= '0;
            sig_rd_q    <= 1'b0;
            sig_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p_ack_q     <= '0;
            p_tout_q    <= 1'b0;
            err_q       <= 1'b0;
            p_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wd_cnt_q    <= wd_cnt_d;
            grant_q     <= grant_d;
            sig_rd_q    <= sig_rd_d;
            sig_wr_q    <= sig_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p_ack_q     <= p_ack_d;
            p_tout_q    <= p_tout_d;
            err_q       <= err_d;
            p_rdata_q   <= p_rdata_d;
        end
    end

    assign P_ACK     = p_ack_q;
    assign P_TOUT    = p_tout_q;
    assign P_RDATA   = p_rdata_q;
    assign GRANT_ID  = ($clog2(c_ARB_PORTS_MAX))'(grant_q);
    assign BUSY      = (state_q != c_ARB_IDLE);
    assign ERR       = err_q;
    assign SIG_RD    = sig_rd_q;
    assign SIG_WR    = sig_wr_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: requests and memory latency are drawn at random and
// checked against a transaction-level round-robin model with an expected-grant queue.
module tb_memory_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int TO = 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [N-1:0]      p_rd      = '0;
    logic [N-1:0]      p_wr      = '0;
    logic [N*AW-1:0]   p_addr    = '0;
    logic [N*DW-1:0]   p_wdata   = '0;
    logic              mem_ack   = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic [N-1:0]      p_ack;
    logic              p_tout;
    logic [DW-1:0]     p_rdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err;
    logic              sig_rd;
    logic              sig_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [1:0]        dbg_state;

    // Requester model: one pending request per port.
    bit            mrd[N];
    bit            mwr[N];
    logic [AW-1:0] maddr[N];
    logic [DW-1:0] mdata[N];
    int            next_ptr;
    int            last_grant;
    bit            err_exp;
    logic [DW-1:0] last_rdata;
    logic [1:0]    exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .N_PORTS         (N),
        .c_ADDR_SIZE     (AW),
        .c_RAM_DATA_SIZE (DW),
        .TIMEOUT         (TO)
    ) dut (
        .CACHE_CLK   (clk),
        .CACHE_RESET (rst_n),
        .P_RD        (p_rd),
        .P_WR        (p_wr),
        .P_ADDR      (p_addr),
        .P_WDATA     (p_wdata),
        .P_ACK       (p_ack),
        .P_TOUT      (p_tout),
        .P_RDATA     (p_rdata),
        .GRANT_ID    (grant_id),
        .BUSY        (busy),
        .ERR         (err),
        .SIG_RD      (sig_rd),
        .SIG_WR      (sig_wr),
        .MEM_ADDR    (mem_addr),
        .MEM_WDATA   (mem_wdata),
        .MEM_ACK     (mem_ack),
        .MEM_RDATA   (mem_rdata),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) begin
            if (mrd[i] || mwr[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Round-robin rule: first requesting port at or after next_ptr, modulo N.
    function automatic int pick();
        for (int j = 0; j < N; j++) begin
            if (mrd[(next_ptr + j) % N] || mwr[(next_ptr + j) % N]) return (next_ptr + j) % N;
        end
        return -1;
    endfunction

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            p_rd[i]               = mrd[i];
            p_wr[i]               = mwr[i];
            p_addr[i*AW +: AW]    = maddr[i];
            p_wdata[i*DW +: DW]   = mdata[i];
        end
    endtask

    task automatic post(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        mrd[p]   = rd;
        mwr[p]   = wr;
        maddr[p] = a;
        mdata[p] = d;
    endtask

    task automatic model_reset();
        next_ptr   = 0;
        last_grant = 0;
        err_exp    = 1'b0;
        last_rdata = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) post(i, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic check_reset_outputs();
        check("rst_sig_rd", sig_rd, 0);
        check("rst_sig_wr", sig_wr, 0);
        check("rst_p_ack", p_ack, 0);
        check("rst_p_tout", p_tout, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_grant", grant_id, 0);
        check("rst_rdata", p_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
    endtask

    // One IDLE cycle with nothing requested; a stray MEM_ACK must be ignored.
    task automatic idle_cycle();
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = rand_line();
        tick();
        mem_ack = 1'b0;
        check("idle_sig", {sig_rd, sig_wr}, 0);
        check("idle_ack", p_ack, 0);
        check("idle_tout", p_tout, 0);
        check("idle_busy", busy, 0);
        check("idle_grant", grant_id, last_grant);
        check("idle_rdata", p_rdata, last_rdata);
        check("idle_err", err, err_exp);
    endtask

    // Serves the model's next winner; lat = cycles without MEM_ACK after issue.
    task automatic run_transfer(input int lat, input bit stray_idle, input bit stray_gap,
                                input logic [DW-1:0] line);
        int           g;
        bit           wr;
        logic [N-1:0] onehot;
        logic [1:0]   eg;
        g = pick();
        if (g < 0) begin
            n_bad++;
            $display("FAIL pick: no pending request");
            return;
        end
        wr        = mwr[g];
        onehot    = '0;
        onehot[g] = 1'b1;
        exp_q.push_back(2'(g));
        drive_ports();
        mem_ack   = stray_idle;
        mem_rdata = rand_line();
        tick();
        mem_ack = 1'b0;
        if (mrd[g] && mwr[g]) err_exp = 1'b1;
        check("issue_sig_rd", sig_rd, !wr);
        check("issue_sig_wr", sig_wr, wr);
        check("issue_addr", mem_addr, maddr[g]);
        check("issue_wdata", mem_wdata, mdata[g]);
        check("issue_grant", grant_id, g);
        check("issue_busy", busy, 1);
        check("issue_ack", p_ack, 0);
        check("issue_err", err, err_exp);
        for (int c = 1; c <= lat && c < TO; c++) begin
            tick();
            check("hold_sig", {sig_rd, sig_wr}, {!wr, wr});
            check("hold_addr", mem_addr, maddr[g]);
            check("hold_wdata", mem_wdata, mdata[g]);
            check("hold_ack", p_ack, 0);
            check("hold_busy", busy, 1);
        end
        if (lat >= TO) begin
            tick();
            err_exp = 1'b1;
            eg      = exp_q.pop_front();
            check("to_ack", p_ack, onehot);
            check("to_tout", p_tout, 1);
            check("to_sig", {sig_rd, sig_wr}, 0);
            check("to_err", err, 1);
            check("to_grant", grant_id, eg);
            mrd[g] = 1'b0;
            mwr[g] = 1'b0;
            drive_ports();
            for (int c = TO; c < lat; c++) begin
                tick();
                check("drain_ack", p_ack, 0);
                check("drain_tout", p_tout, 0);
                check("drain_sig", {sig_rd, sig_wr}, 0);
                check("drain_busy", busy, 1);
            end
            mem_ack   = 1'b1;
            mem_rdata = line;
            tick();
            mem_ack = 1'b0;
            check("late_ack", p_ack, 0);
            check("late_tout", p_tout, 0);
            check("late_busy", busy, 1);
            check("late_rdata", p_rdata, last_rdata);
        end else begin
            mem_ack   = 1'b1;
            mem_rdata = line;
            tick();
            mem_ack = 1'b0;
            if (!wr) last_rdata = line;
            eg = exp_q.pop_front();
            check("ack_vec", p_ack, onehot);
            check("ack_tout", p_tout, 0);
            check("ack_sig", {sig_rd, sig_wr}, 0);
            check("ack_rdata", p_rdata, last_rdata);
            check("ack_grant", grant_id, eg);
            mrd[g] = 1'b0;
            mwr[g] = 1'b0;
            drive_ports();
        end
        next_ptr   = (g + 1) % N;
        last_grant = g;
        mem_ack    = stray_gap;
        tick();
        mem_ack = 1'b0;
        check("gap_ack", p_ack, 0);
        check("gap_tout", p_tout, 0);
        check("gap_sig", {sig_rd, sig_wr}, 0);
        check("gap_busy", busy, 0);
        check("gap_grant", grant_id, g);
        check("gap_err", err, err_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int lat;
        int r;
        model_reset();
        drive_ports();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        idle_cycle();
        idle_cycle();

        // Port 0 read with the longest latency that still completes normally.
        post(0, 1'b1, 1'b0, 16'h0040, 64'h0);
        run_transfer(TO - 1, 1'b0, 1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210);

        // Ports 0 and 1 requesting continuously.
        for (int t = 0; t < 4; t++) begin
            if (!mrd[0] && !mwr[0]) post(0, 1'b1, 1'b0, 16'($urandom), rand_line());
            if (!mrd[1] && !mwr[1]) post(1, 1'b1, 1'b0, 16'($urandom), rand_line());
            run_transfer($urandom_range(0, 4), 1'b0, 1'b0, rand_line());
        end
        while (any_pending()) run_transfer(1, 1'b0, 1'b0, rand_line());

        post(1, 1'b0, 1'b1, 16'h00A0, 128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
        run_transfer(6, 1'b1, 1'b1, rand_line());

        // Both strobes from one port: served as a write, ERR set.
        post(0, 1'b1, 1'b1, 16'h1234, rand_line());
        run_transfer(2, 1'b0, 1'b0, rand_line());

        // Reset in the middle of WAIT.
        post(2, 1'b1, 1'b0, 16'h0300, rand_line());
        drive_ports();
        tick();
        check("pre_rst_sig_rd", sig_rd, 1);
        tick();
        rst_n = 1'b0;
        model_reset();
        drive_ports();
        tick();
        check_reset_outputs();
        rst_n = 1'b1;
        post(1, 1'b1, 1'b0, 16'h0011, rand_line());
        post(0, 1'b1, 1'b0, 16'h0022, rand_line());
        run_transfer(3, 1'b0, 1'b0, rand_line());
        check("post_rst_first_grant", last_grant, 0);
        run_transfer(0, 1'b0, 1'b0, rand_line());

        // Watchdog expiry with port 1 waiting through DRAIN; ACK exactly at the limit first.
        post(2, 1'b1, 1'b0, 16'h0500, rand_line());
        run_transfer(TO - 1, 1'b0, 1'b0, rand_line());
        post(1, 1'b1, 1'b0, 16'h0600, rand_line());
        post(0, 1'b0, 1'b1, 16'h0700, rand_line());
        run_transfer(TO + 3, 1'b0, 1'b0, rand_line());
        while (any_pending()) run_transfer(2, 1'b0, 1'b0, rand_line());

        for (int t = 0; t < 250; t++) begin
            if (!any_pending() && $urandom_range(0, 2) == 0) idle_cycle();
            for (int i = 0; i < N; i++) begin
                if (!mrd[i] && !mwr[i] && $urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 9);
                    post(i, r == 0 || r > 4, r <= 4, 16'($urandom), rand_line());
                end
            end
            if (!any_pending()) post($urandom_range(0, N - 1), 1'b1, 1'b0, 16'($urandom), rand_line());
            lat = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
            run_transfer(lat, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), rand_line());
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
